cam_field_timing_gen: RTL and testbench
=======================================

# cam_field_timing_gen

Synthetic interlaced camera timing source for the `cam_pclk` domain. It generates `cam_line_valid`, `cam_field_toggle` and an 8-bit test-pattern pixel stream that mimic a real sensor's field and line structure. It sits where the camera front-end normally drives the capture path. The field line counter and line buffer can therefore be exercised in silicon and simulation without a sensor. Per-field active-line counts are parameterised so that downstream line-count measurement can be checked against known values.

## Interface
- `H_ACTIVE`, 720: active pixels per line (1..2047)
- `H_BLANK`, 144: blank cycles per line (≥1); `H_TOTAL = H_ACTIVE + H_BLANK` (≤4095)
- `V_BLANK_LINES`, 25: blank lines at the start of each field (≥1)
- `LINES_F0`, 288: active lines in field 0 (≥1; `V_BLANK_LINES + LINES_F0` ≤ 1023)
- `LINES_F1`, 287: active lines in field 1 (same limits as `LINES_F0`)
- `cam_pclk`  in  1  pixel clock; the only clock
- `cam_reset`  in  1  synchronous, active-high reset
- `gen_enable`  in  1  run request, level-sensitive
- `cam_line_valid`  out  1  high during active pixels
- `cam_field_toggle`  out  1  inverts on the first cycle of every field
- `cam_field_id`  out  1  0 = field 0, 1 = field 1
- `cam_pixel_data`  out  8  test pattern; 0 when `cam_line_valid` = 0
- `cam_active_line`  out  10  active-line index within the field; 0 outside active lines
- `field_done`  out  1  one-cycle pulse on the last cycle of each field
- `lines_sent_last`  out  10  active lines sent in the most recently completed field

## Operation
- States:
  - IDLE: all stream outputs low.
  - RUN: counters `h` (12 bit, 0..H_TOTAL−1) and `v` (10 bit, 0..V_BLANK_LINES+N−1), where N = `LINES_F0` or `LINES_F1` per `cam_field_id`.
- IDLE→RUN occurs when `gen_enable` = 1 is sampled. On the next edge:
  - `h` = 0, `v` = 0
  - `cam_field_id` = 0
  - `cam_field_toggle` inverts
- In RUN, `h` increments every cycle and wraps to 0 after `H_TOTAL−1`; `v` increments on each `h` wrap.
- End of field is the cycle with `h` = H_TOTAL−1 and `v` = last. In that cycle:
  - `field_done` = 1
  - `lines_sent_last` ← N on the same edge that the pulse rises
- After end of field:
  - If `gen_enable` = 1, the next cycle starts a new field: `h` = `v` = 0, `cam_field_id` inverts, `cam_field_toggle` inverts.
  - If `gen_enable` = 0, return to IDLE with no toggle.
- Dropping `gen_enable` mid-field has no effect until the field ends. Fields are never truncated.
- Starting from IDLE always begins at field 0.
- Active region is `v ≥ V_BLANK_LINES` and `h < H_ACTIVE`. Within it:
  - `cam_line_valid` = 1
  - `cam_active_line` = `v − V_BLANK_LINES`
  - `cam_pixel_data` = `(h + cam_active_line + 128·cam_field_id) mod 256`
- Field toggles always fall inside vertical blanking, so a toggle edge never coincides with a `cam_line_valid` rising edge.
- Reset values:
  - State IDLE, `h` = `v` = 0
  - `cam_line_valid`, `cam_field_toggle`, `cam_field_id`, `field_done` = 0
  - `cam_pixel_data`, `cam_active_line`, `lines_sent_last` = 0
- Reset mid-field:
  - Outputs take their reset values on the next edge and the partial field is discarded; `lines_sent_last` is not updated.
  - A reset while `cam_field_toggle` = 1 produces an edge. Downstream logic must be reset in the same cycle.

## Timing
- All outputs are registered and mutually aligned: each cycle's outputs reflect the same (`h`, `v`).
- Enable latency: `gen_enable` sampled high in IDLE at edge k produces the toggle edge and `h` = `v` = 0 at edge k+1.
- Field length is `(V_BLANK_LINES + N) · H_TOTAL` cycles, counted toggle edge to toggle edge, with no idle gap between fields.
- The first `cam_line_valid` rise of a field occurs `V_BLANK_LINES · H_TOTAL` cycles after that field's toggle edge.
- `field_done` occurs in the cycle immediately before the next toggle edge, or before the IDLE entry.

## Test plan
All scenarios use `H_ACTIVE` = 4, `H_BLANK` = 2, `V_BLANK_LINES` = 1, `LINES_F0` = 3, `LINES_F1` = 2.

- Reset, then hold `gen_enable` = 0 for 50 cycles → all outputs stay 0 and no toggle edge occurs.
- Assert `gen_enable` at cycle 0 → toggle rises at cycle 1; `cam_line_valid` is high at cycles 7–10, 13–16 and 19–22; `field_done` = 1 at cycle 24 with `lines_sent_last` = 3; toggle falls at cycle 25 with `cam_field_id` = 1.
- Continuous run → field 1 is 18 cycles with 2 active lines and `lines_sent_last` = 2. The pixel sequence on field-1 line 0 is 128,129,130,131.
- Drop `gen_enable` during field 1's second active line → field completes, then IDLE with no further toggle. Re-enabling restarts at field 0.
- Assert `cam_reset` mid-field while toggle = 1 → all outputs 0 next cycle and `lines_sent_last` keeps its previous value.
- Pair with the field line counter for four fields → the counter reports 3, 2, 3, 2.

Source files
------------

// File: rtl/cam_field_timing_if.sv
// Stream bundle between the synthetic field timing source and its capture-side consumer.
// The run request travels alongside the timing outputs it controls.
interface cam_field_timing_if;
    logic       gen_enable;
    logic       cam_line_valid;
    logic       cam_field_toggle;
    logic       cam_field_id;
    logic [7:0] cam_pixel_data;
    logic [9:0] cam_active_line;
    logic       field_done;
    logic [9:0] lines_sent_last;

    modport master (
        input  gen_enable,
        output cam_line_valid, cam_field_toggle, cam_field_id, cam_pixel_data,
               cam_active_line, field_done, lines_sent_last
    );

    modport slave (
        output gen_enable,
        input  cam_line_valid, cam_field_toggle, cam_field_id, cam_pixel_data,
               cam_active_line, field_done, lines_sent_last
    );
endinterface

// File: rtl/cam_field_timing_gen.sv
// Synthetic interlaced camera timing source: alternating fields of blank and active lines
// carrying a field/line/pixel dependent test pattern, all outputs registered and aligned.
module cam_field_timing_gen #(
    parameter int H_ACTIVE      = 720,
    parameter int H_BLANK       = 144,
    parameter int V_BLANK_LINES = 25,
    parameter int LINES_F0      = 288,
    parameter int LINES_F1      = 287
) (
    input  logic               cam_pclk,
    input  logic               cam_reset,
    cam_field_timing_if.master bus
);
    localparam int         H_TOTAL = H_ACTIVE + H_BLANK;
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [9:0]  V_BLK  = 10'(V_BLANK_LINES);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    function automatic logic [9:0] lines_in_field(input logic fid);
        return fid ? 10'(LINES_F1) : 10'(LINES_F0);
    endfunction

    function automatic logic [9:0] last_line(input logic fid);
        return V_BLK + lines_in_field(fid) - 10'd1;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [11:0] h_r, h_nxt_s;
    logic [9:0]  v_r, v_nxt_s;
    logic        fid_r, fid_nxt_s;
    logic        tog_r, tog_nxt_s;
    logic        end_of_field_s;
    logic        active_row_s, valid_nxt_s, done_nxt_s;
    logic [9:0]  aline_nxt_s;
    logic [7:0]  pix_nxt_s;

    assign end_of_field_s = (state_r == ST_RUN) && (h_r == H_LAST) && (v_r == last_line(fid_r));

    // Next-state: raster counters, field parity and toggle sequencing
    always_comb begin
        state_nxt_s = state_r;
        h_nxt_s     = h_r;
        v_nxt_s     = v_r;
        fid_nxt_s   = fid_r;
        tog_nxt_s   = tog_r;
        case (state_r)
            ST_IDLE: begin
                h_nxt_s   = 12'd0;
                v_nxt_s   = 10'd0;
                fid_nxt_s = 1'b0;
                if (bus.gen_enable) begin
                    state_nxt_s = ST_RUN;
                    tog_nxt_s   = ~tog_r;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (end_of_field_s) begin
                    h_nxt_s = 12'd0;
                    v_nxt_s = 10'd0;
                    if (bus.gen_enable) begin
                        fid_nxt_s = ~fid_r;
                        tog_nxt_s = ~tog_r;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        fid_nxt_s   = 1'b0;
                    end
                end else if (h_r == H_LAST) begin
                    h_nxt_s = 12'd0;
                    v_nxt_s = v_r + 10'd1;
                end else begin
                    h_nxt_s = h_r + 12'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                h_nxt_s     = 12'd0;
                v_nxt_s     = 10'd0;
                fid_nxt_s   = 1'b0;
            end
        endcase
    end

    // Output decode from next raster position so every registered output shares one (h, v)
    always_comb begin
        active_row_s = (state_nxt_s == ST_RUN) && (v_nxt_s >= V_BLK);
        valid_nxt_s  = active_row_s && (h_nxt_s < H_ACT);
        done_nxt_s   = (state_nxt_s == ST_RUN) && (h_nxt_s == H_LAST) &&
                       (v_nxt_s == last_line(fid_nxt_s));
        if (active_row_s) begin
            aline_nxt_s = v_nxt_s - V_BLK;
        end else begin
            aline_nxt_s = 10'd0;
        end
        if (valid_nxt_s) begin
            pix_nxt_s = h_nxt_s[7:0] + aline_nxt_s[7:0] + {fid_nxt_s, 7'd0};
        end else begin
            pix_nxt_s = 8'd0;
        end
    end

    // State, counters and registered stream outputs
    always_ff @(posedge cam_pclk) begin
        if (cam_reset) begin
            state_r                <= ST_IDLE;
            h_r                    <= 12'd0;
            v_r                    <= 10'd0;
            fid_r                  <= 1'b0;
            tog_r                  <= 1'b0;
            bus.cam_line_valid     <= 1'b0;
            bus.cam_field_toggle   <= 1'b0;
            bus.cam_field_id       <= 1'b0;
            bus.cam_pixel_data     <= 8'd0;
            bus.cam_active_line    <= 10'd0;
            bus.field_done         <= 1'b0;
            // A reset that interrupts a field keeps the last completed count; from IDLE it clears.
            if (state_r != ST_RUN) begin
                bus.lines_sent_last <= 10'd0;
            end else begin
                bus.lines_sent_last <= bus.lines_sent_last;
            end
        end else begin
            state_r                <= state_nxt_s;
            h_r                    <= h_nxt_s;
            v_r                    <= v_nxt_s;
            fid_r                  <= fid_nxt_s;
            tog_r                  <= tog_nxt_s;
            bus.cam_line_valid     <= valid_nxt_s;
            bus.cam_field_toggle   <= tog_nxt_s;
            bus.cam_field_id       <= fid_nxt_s;
            bus.cam_pixel_data     <= pix_nxt_s;
            bus.cam_active_line    <= aline_nxt_s;
            bus.field_done         <= done_nxt_s;
            if (done_nxt_s) begin
                bus.lines_sent_last <= lines_in_field(fid_nxt_s);
            end else begin
                bus.lines_sent_last <= bus.lines_sent_last;
            end
        end
    end
endmodule

// File: tb/tb_cam_field_timing_gen.sv
// Directed bench for cam_field_timing_gen with a 4+2 pixel line, 1 blank line, fields of 3 and 2 lines.
module tb_cam_field_timing_gen;
    logic cam_pclk = 1'b0;
    logic cam_reset;
    cam_field_timing_if bus ();

    cam_field_timing_gen #(
        .H_ACTIVE(4), .H_BLANK(2), .V_BLANK_LINES(1), .LINES_F0(3), .LINES_F1(2)
    ) dut (
        .cam_pclk (cam_pclk),
        .cam_reset(cam_reset),
        .bus      (bus)
    );

    always #5 cam_pclk = ~cam_pclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d, want %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge cam_pclk);
        @(negedge cam_pclk);
    endtask

    function automatic logic [31:0] all_out();
        return {bus.cam_line_valid, bus.cam_field_toggle, bus.cam_field_id, bus.field_done,
                bus.cam_pixel_data, bus.cam_active_line, bus.lines_sent_last};
    endfunction

    // Active windows of the first two fields: start cycle, active line, field id
    int win_start [5] = '{7, 13, 19, 31, 37};
    int win_line  [5] = '{0, 1, 2, 0, 1};
    int win_fid   [5] = '{0, 0, 0, 1, 1};

    int exp_valid, exp_pix, exp_aline, exp_tog, exp_fid, exp_done, exp_lines;
    int fld_lines [$];
    int done_lines [$];
    int cnt_rise, n_edges;
    logic prev_tog, prev_valid;

    initial begin
        cam_reset      = 1'b1;
        bus.gen_enable = 1'b0;
        repeat (3) step();
        chk("reset_state", 0, all_out(), 32'd0);
        cam_reset = 1'b0;

        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_hold", i, all_out(), 32'd0);
        end

        // Cycle 0: enable driven; cycle c is the interval after the c-th following edge.
        bus.gen_enable = 1'b1;
        for (int c = 1; c <= 42; c++) begin
            step();
            exp_valid = 0;
            exp_pix   = 0;
            for (int w = 0; w < 5; w++) begin
                if (c >= win_start[w] && c < win_start[w] + 4) begin
                    exp_valid = 1;
                    exp_pix   = c - win_start[w] + win_line[w] + 128 * win_fid[w];
                end
            end
            if (c >= 7 && c <= 24)       exp_aline = (c - 7) / 6;
            else if (c >= 31 && c <= 42) exp_aline = (c - 31) / 6;
            else                         exp_aline = 0;
            exp_tog   = (c <= 24) ? 1 : 0;
            exp_fid   = (c <= 24) ? 0 : 1;
            exp_done  = (c == 24 || c == 42) ? 1 : 0;
            exp_lines = (c < 24) ? 0 : ((c < 42) ? 3 : 2);
            chk("line_valid",  c, 32'(bus.cam_line_valid),   32'(exp_valid));
            chk("pixel",       c, 32'(bus.cam_pixel_data),   32'(exp_pix));
            chk("active_line", c, 32'(bus.cam_active_line),  32'(exp_aline));
            chk("toggle",      c, 32'(bus.cam_field_toggle), 32'(exp_tog));
            chk("field_id",    c, 32'(bus.cam_field_id),     32'(exp_fid));
            chk("field_done",  c, 32'(bus.field_done),       32'(exp_done));
            chk("lines_sent",  c, 32'(bus.lines_sent_last),  32'(exp_lines));
            if (c == 38) bus.gen_enable = 1'b0;
        end

        // Field 1 completed with enable low: IDLE, no toggle, count of 2 retained
        for (int c = 43; c <= 50; c++) begin
            step();
            chk("idle_after_drop", c, all_out(), 32'd2);
        end

        bus.gen_enable = 1'b1;
        prev_tog   = 1'b0;
        prev_valid = 1'b0;
        cnt_rise   = 0;
        n_edges    = 0;
        for (int c = 51; c <= 140; c++) begin
            step();
            if (c == 51) begin
                chk("restart_toggle", c, 32'(bus.cam_field_toggle), 32'd1);
                chk("restart_fid",    c, 32'(bus.cam_field_id),     32'd0);
            end
            if (bus.cam_field_toggle !== prev_tog) begin
                if (n_edges > 0) fld_lines.push_back(cnt_rise);
                n_edges++;
                cnt_rise = 0;
            end
            if (bus.cam_line_valid && !prev_valid) cnt_rise++;
            if (bus.field_done) done_lines.push_back(int'(bus.lines_sent_last));
            prev_tog   = bus.cam_field_toggle;
            prev_valid = bus.cam_line_valid;
        end
        chk("toggle_edges", 140, 32'(n_edges), 32'd5);
        chk("field_count_n", 140, 32'(fld_lines.size()), 32'd4);
        chk("done_count_n",  140, 32'(done_lines.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("field_lines", i, (i < fld_lines.size())  ? 32'(fld_lines[i])  : 32'hFFFF_FFFF,
                (i % 2 == 0) ? 32'd3 : 32'd2);
            chk("done_lines",  i, (i < done_lines.size()) ? 32'(done_lines[i]) : 32'hFFFF_FFFF,
                (i % 2 == 0) ? 32'd3 : 32'd2);
        end
        chk("pre_reset_toggle", 140, 32'(bus.cam_field_toggle), 32'd1);

        cam_reset      = 1'b1;
        bus.gen_enable = 1'b0;
        step();
        chk("reset_midfield", 141, all_out(), 32'd2);
        cam_reset = 1'b0;
        step();
        chk("idle_after_reset", 142, all_out(), 32'd2);
        cam_reset = 1'b1;
        step();
        chk("reset_from_idle", 143, all_out(), 32'd0);
        cam_reset = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
